// File: rtl/regfile_port_arbiter.sv
// Register-file port arbiter: shares the write port and read port 2 between
// the core and a debug/loader host. It runs an optional post-reset clear
// sequence, and a starvation guard forces one debug slot.
module regfile_port_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned NREGS      = 32,
    parameter int unsigned INIT_CLEAR = 1,
    parameter int unsigned CLR_START  = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              core_wr,
    input  logic [ADDR_W-1:0] core_waddr,
    input  logic [DATA_W-1:0] core_din,
    input  logic [ADDR_W-1:0] core_raddr2,
    input  logic              core_rd2_en,
    output logic              core_stall,
    output logic              init_done,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,
    output logic              rf_wr,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_din,
    output logic [ADDR_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_dout2
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NREGS - 1);
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(CLR_START);
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(STARVE_MAX);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;
    localparam logic   RESET_DONE  = (INIT_CLEAR == 0);

    state_t            state, state_next;
    logic [ADDR_W-1:0] clr_ptr, clr_ptr_next;
    logic [CNT_W-1:0]  starve_cnt, starve_next;
    logic              init_done_next;
    logic [DATA_W-1:0] rdata_next;
    logic              rvalid_next;
    logic              core_busy;

    // State and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= RESET_STATE;
            clr_ptr    <= FIRST_ADDR;
            starve_cnt <= '0;
            init_done  <= RESET_DONE;
            dbg_rdata  <= '0;
            dbg_rvalid <= 1'b0;
        end else begin
            state      <= state_next;
            clr_ptr    <= clr_ptr_next;
            starve_cnt <= starve_next;
            init_done  <= init_done_next;
            dbg_rdata  <= rdata_next;
            dbg_rvalid <= rvalid_next;
        end
    end

    // Next-state, grant decision and register-file port muxing.
    always_comb begin
        state_next     = state;
        clr_ptr_next   = clr_ptr;
        starve_next    = starve_cnt;
        init_done_next = init_done;
        rdata_next     = dbg_rdata;
        rvalid_next    = 1'b0;
        core_busy      = core_wr | core_rd2_en;
        core_stall     = 1'b0;
        dbg_gnt        = 1'b0;
        rf_wr          = core_wr;
        rf_waddr       = core_waddr;
        rf_din         = core_din;
        rf_raddr2      = core_raddr2;

        case (state)
            ST_CLEAR: begin
                // Zero one register per cycle; the core and debug wait.
                rf_wr        = 1'b1;
                rf_waddr     = clr_ptr;
                rf_din       = '0;
                core_stall   = 1'b1;
                starve_next  = '0;
                clr_ptr_next = clr_ptr + ADDR_W'(1);
                if (clr_ptr == LAST_ADDR) begin
                    state_next     = ST_IDLE;
                    init_done_next = 1'b1;
                end
            end
            ST_IDLE: begin
                dbg_gnt    = dbg_req & (~core_busy | (starve_cnt == CNT_MAX));
                core_stall = dbg_gnt & core_busy;
                if (dbg_gnt) begin
                    if (dbg_we) begin
                        // r0 is hardwired; the grant is still consumed.
                        rf_wr    = (dbg_addr != '0);
                        rf_waddr = dbg_addr;
                        rf_din   = dbg_wdata;
                    end else begin
                        rf_wr       = 1'b0;
                        rf_raddr2   = dbg_addr;
                        rdata_next  = rf_dout2;
                        rvalid_next = 1'b1;
                    end
                end
                if (dbg_gnt || !dbg_req) begin
                    starve_next = '0;
                end else if (starve_cnt != CNT_MAX) begin
                    starve_next = starve_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = RESET_STATE;
            end
        endcase
    end

endmodule
